// File: rtl/clock_pkg.sv
// Shared clock/alarm definitions: time and timer widths, alarm FSM encoding
// and the alarm-time range check.
package clock_pkg;

    localparam int TIME_W  = 6;
    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarmState_t;

    function automatic logic timeValid(input logic [TIME_W-1:0] h,
                                       input logic [TIME_W-1:0] m);
        return (h <= TIME_W'(23)) && (m <= TIME_W'(59));
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: compares a level against its one-cycle-delayed copy.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic inDly;

    always_ff @(posedge clk) begin
        if (rst) inDly <= 1'b0;
        else     inDly <= in;
    end

    assign rise = in & ~inDly;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arm/ring/snooze FSM with alarm-time storage and button edges.
// Optional ALARM_BLINK_EN makes ring toggle on every second while ringing.
module alarm_sequencer
    import clock_pkg::*;
#(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1s,
    input  logic [TIME_W-1:0] hour,
    input  logic [TIME_W-1:0] min,
    input  logic [TIME_W-1:0] sec,
    input  logic              arm,
    input  logic              set_valid,
    input  logic [TIME_W-1:0] set_hour,
    input  logic [TIME_W-1:0] set_min,
    input  logic              btn_stop,
    input  logic              btn_snooze,
    output logic [TIME_W-1:0] alarm_hour,
    output logic [TIME_W-1:0] alarm_min,
    output logic              ring,
    output logic [1:0]        state,
    output logic [1:0]        snooze_cnt
);

    localparam logic [TIMER_W-1:0] RING_LAST   = TIMER_W'(RING_TIMEOUT_S - 1);
    localparam logic [TIMER_W-1:0] SNOOZE_LAST = TIMER_W'(SNOOZE_S - 1);
    localparam logic [1:0]         SNOOZE_MAX  = 2'(MAX_SNOOZE);

    alarmState_t        curState, nextState;
    logic [TIMER_W-1:0] timer, timerNext;
    logic [1:0]         snoozeCnt, snoozeNext;
    logic [TIME_W-1:0]  alarmHourR, alarmMinR;
    logic               stopRise, snoozeRise;
    logic               loadOk, alarmMatch;

    edge_detect stopEdge (
        .clk  (clk),
        .rst  (rst),
        .in   (btn_stop),
        .rise (stopRise)
    );

    edge_detect snoozeEdge (
        .clk  (clk),
        .rst  (rst),
        .in   (btn_snooze),
        .rise (snoozeRise)
    );

    assign loadOk     = set_valid && timeValid(set_hour, set_min);
    assign alarmMatch = tick_1s && (hour == alarmHourR) && (min == alarmMinR) && (sec == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            curState   <= IDLE;
            timer      <= '0;
            snoozeCnt  <= '0;
            alarmHourR <= '0;
            alarmMinR  <= '0;
        end else begin
            curState  <= nextState;
            timer     <= timerNext;
            snoozeCnt <= snoozeNext;
            if (loadOk) begin
                alarmHourR <= set_hour;
                alarmMinR  <= set_min;
            end
        end
    end

    // Priority: disarm, then alarm reload, then buttons, then the seconds tick.
    always_comb begin
        nextState  = curState;
        timerNext  = timer;
        snoozeNext = snoozeCnt;
        if (!arm) begin
            nextState  = IDLE;
            timerNext  = '0;
            snoozeNext = '0;
        end else if (loadOk && (curState == RINGING || curState == SNOOZE)) begin
            nextState  = ARMED;
            timerNext  = '0;
            snoozeNext = '0;
        end else begin
            case (curState)
                IDLE: begin
                    nextState  = ARMED;
                    timerNext  = '0;
                    snoozeNext = '0;
                end
                ARMED: begin
                    if (alarmMatch) begin
                        nextState = RINGING;
                        timerNext = '0;
                    end
                end
                RINGING: begin
                    if (stopRise) begin
                        nextState  = ARMED;
                        timerNext  = '0;
                        snoozeNext = '0;
                    end else if (snoozeRise) begin
                        if (snoozeCnt < SNOOZE_MAX) begin
                            nextState  = SNOOZE;
                            timerNext  = '0;
                            snoozeNext = snoozeCnt + 2'd1;
                        end
                    end else if (tick_1s) begin
                        if (timer == RING_LAST) begin
                            nextState  = ARMED;
                            timerNext  = '0;
                            snoozeNext = '0;
                        end else begin
                            timerNext = timer + TIMER_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (stopRise) begin
                        nextState  = ARMED;
                        timerNext  = '0;
                        snoozeNext = '0;
                    end else if (tick_1s && !snoozeRise) begin
                        if (timer == SNOOZE_LAST) begin
                            nextState = RINGING;
                            timerNext = '0;
                        end else begin
                            timerNext = timer + TIMER_W'(1);
                        end
                    end
                end
                default: begin
                    nextState  = IDLE;
                    timerNext  = '0;
                    snoozeNext = '0;
                end
            endcase
        end
    end

`ifdef ALARM_BLINK_EN
    logic blinkR, blinkNext;

    // Phase starts high on entry to RINGING and flips on every counted tick.
    always_comb begin
        blinkNext = 1'b0;
        if (nextState == RINGING) begin
            if (curState != RINGING)
                blinkNext = 1'b1;
            else if (tick_1s && !stopRise && !snoozeRise)
                blinkNext = ~blinkR;
            else
                blinkNext = blinkR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) blinkR <= 1'b0;
        else     blinkR <= blinkNext;
    end

    assign ring = blinkR && (curState == RINGING);
`else
    assign ring = (curState == RINGING);
`endif

    assign state      = curState;
    assign snooze_cnt = snoozeCnt;
    assign alarm_hour = alarmHourR;
    assign alarm_min  = alarmMinR;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: directed stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       rst, tick_1s, arm, set_valid, btn_stop, btn_snooze;
    logic [5:0] hour, min, sec, set_hour, set_min;
    logic [5:0] alarm_hour, alarm_min;
    logic       ring;
    logic [1:0] state, snooze_cnt;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic       rg;
        logic [1:0] cnt;
        logic [5:0] ah;
        logic [5:0] am;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monE;
    int         testsRun = 0;
    int         testsFailed = 0;
    logic [5:0] expAh = '0;
    logic [5:0] expAm = '0;
    logic       drainTimeout = 1'b0;
    logic       drainReported = 1'b0;
    logic [3:0] blinkExp;

    always #5 clk = ~clk;

    alarm_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1s    (tick_1s),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .arm        (arm),
        .set_valid  (set_valid),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .btn_stop   (btn_stop),
        .btn_snooze (btn_snooze),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .ring       (ring),
        .state      (state),
        .snooze_cnt (snooze_cnt)
    );

    // Monitor: every falling edge, compare all pending expectations.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            monE = expQ.pop_front();
            testsRun++;
            if (state !== monE.st || ring !== monE.rg || snooze_cnt !== monE.cnt ||
                alarm_hour !== monE.ah || alarm_min !== monE.am) begin
                testsFailed++;
                $display("[TB] FAIL %s: got state=%0d ring=%0d snooze_cnt=%0d alarm=%0d:%0d, expected state=%0d ring=%0d snooze_cnt=%0d alarm=%0d:%0d",
                         monE.name, state, ring, snooze_cnt, alarm_hour, alarm_min,
                         monE.st, monE.rg, monE.cnt, monE.ah, monE.am);
            end
        end
        if (drainTimeout && !drainReported) begin
            drainReported = 1'b1;
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: expectation queue not emptied, %0d left, required 0", expQ.size());
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] st,
                               input logic rg, input logic [1:0] cnt);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.rg   = rg;
        e.cnt  = cnt;
        e.ah   = expAh;
        e.am   = expAm;
        expQ.push_back(e);
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1s = 1'b1;
            applyStimulus();
            tick_1s = 1'b0;
            applyStimulus();
        end
    endtask

    task automatic press(input logic stop, input logic snz);
        btn_stop   = stop;
        btn_snooze = snz;
        applyStimulus();
        btn_stop   = 1'b0;
        btn_snooze = 1'b0;
        applyStimulus();
    endtask

    task automatic setTime(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        hour = h;
        min  = m;
        sec  = s;
    endtask

    task automatic loadAlarm(input logic [5:0] h, input logic [5:0] m);
        set_valid = 1'b1;
        set_hour  = h;
        set_min   = m;
        applyStimulus();
        set_valid = 1'b0;
    endtask

    initial begin
`ifdef ALARM_BLINK_EN
        blinkExp = 4'b1010;
`else
        blinkExp = 4'b1111;
`endif
        rst = 1'b1; tick_1s = 1'b0; arm = 1'b0; set_valid = 1'b0;
        btn_stop = 1'b0; btn_snooze = 1'b0; set_hour = '0; set_min = '0;
        setTime(0, 0, 0);
        applyStimulus();
        applyStimulus();
        checkOutput("reset", 2'd0, 1'b0, 2'd0);

        rst = 1'b0;
        tickN(1);
        checkOutput("idle_match_ignored", 2'd0, 1'b0, 2'd0);

        loadAlarm(7, 30);
        expAh = 7; expAm = 30;
        checkOutput("load_alarm", 2'd0, 1'b0, 2'd0);

        arm = 1'b1;
        applyStimulus();
        checkOutput("arm", 2'd1, 1'b0, 2'd0);

        setTime(7, 29, 59);
        tickN(1);
        checkOutput("pre_match", 2'd1, 1'b0, 2'd0);
        setTime(7, 30, 0);
        applyStimulus();
        checkOutput("match_no_tick", 2'd1, 1'b0, 2'd0);
        tickN(1);
        checkOutput("ring_start", 2'd2, 1'b1, 2'd0);

        btn_snooze = 1'b1;
        applyStimulus();
        checkOutput("snooze1", 2'd3, 1'b0, 2'd1);
        applyStimulus();
        checkOutput("snooze_level_held", 2'd3, 1'b0, 2'd1);
        btn_snooze = 1'b0;
        tickN(299);
        checkOutput("snooze_299", 2'd3, 1'b0, 2'd1);
        tickN(1);
        checkOutput("snooze_expire", 2'd2, 1'b1, 2'd1);

        press(1'b0, 1'b1);
        checkOutput("snooze2", 2'd3, 1'b0, 2'd2);
        tickN(300);
        checkOutput("ring_after_snooze2", 2'd2, 1'b1, 2'd2);
        press(1'b0, 1'b1);
        checkOutput("snooze3", 2'd3, 1'b0, 2'd3);
        tickN(300);
        checkOutput("ring_after_snooze3", 2'd2, 1'b1, 2'd3);
        press(1'b0, 1'b1);
        checkOutput("snooze4_ignored", 2'd2, 1'b1, 2'd3);
        tickN(59);
        checkOutput("ring_59", 2'd2, 1'b1, 2'd3);
        tickN(1);
        checkOutput("ring_timeout", 2'd1, 1'b0, 2'd0);

        tickN(1);
        checkOutput("ring_again", 2'd2, 1'b1, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tickN(1);
            checkOutput($sformatf("ring_tick%0d", i + 1), 2'd2, blinkExp[i], 2'd0);
        end

        press(1'b0, 1'b1);
        checkOutput("snooze_again", 2'd3, 1'b0, 2'd1);
        press(1'b1, 1'b0);
        checkOutput("stop_in_snooze", 2'd1, 1'b0, 2'd0);

        tickN(1);
        checkOutput("ring_for_both", 2'd2, 1'b1, 2'd0);
        press(1'b1, 1'b1);
        checkOutput("stop_beats_snooze", 2'd1, 1'b0, 2'd0);

        tickN(1);
        checkOutput("ring_for_disarm", 2'd2, 1'b1, 2'd0);
        arm = 1'b0;
        applyStimulus();
        checkOutput("disarm", 2'd0, 1'b0, 2'd0);
        arm = 1'b1;
        applyStimulus();
        checkOutput("rearm", 2'd1, 1'b0, 2'd0);

        tickN(1);
        press(1'b0, 1'b1);
        checkOutput("snooze_for_load", 2'd3, 1'b0, 2'd1);
        loadAlarm(6, 15);
        expAh = 6; expAm = 15;
        checkOutput("load_in_snooze", 2'd1, 1'b0, 2'd0);
        loadAlarm(24, 10);
        checkOutput("bad_hour", 2'd1, 1'b0, 2'd0);
        loadAlarm(5, 60);
        checkOutput("bad_min", 2'd1, 1'b0, 2'd0);
        loadAlarm(23, 59);
        expAh = 23; expAm = 59;
        checkOutput("load_max", 2'd1, 1'b0, 2'd0);

        setTime(23, 59, 0);
        tickN(1);
        checkOutput("ring_2359", 2'd2, 1'b1, 2'd0);
        press(1'b0, 1'b1);
        checkOutput("snooze_before_reset", 2'd3, 1'b0, 2'd1);
        rst = 1'b1;
        applyStimulus();
        expAh = 0; expAm = 0;
        checkOutput("reset_in_snooze", 2'd0, 1'b0, 2'd0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("post_reset", 2'd1, 1'b0, 2'd0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) applyStimulus();
        if (expQ.size() > 0) drainTimeout = 1'b1;
        applyStimulus();
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
